cache_line_fill: RTL
====================

// Module: cache_line_fill
// PURPOSE
//  Write-side companion to the tag lookup. On a lookup miss it picks a victim way and invalidates it.
//  It then fetches the line from memory in WORDS_PER_LINE beats, writes the data/tag arrays,
//  and marks the line valid. It sits between the cache miss path and the memory port.
// PARAMETERS
//  N_WAYS          2   associativity
//  N_POW           4   way-index width; 2**N_POW >= N_WAYS
//  TAG_BITS        20  tag width
//  INDEX_BITS      8   set-index width; N_SETS = 2**INDEX_BITS
//  WORDS_PER_LINE  4   32-bit words per line; power of two >= 2
//  DATA_BITS       32  word width
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               async active-low reset
//  miss_valid     in   1               miss request
//  miss_ready     out  1               high only in IDLE
//  miss_tag       in   TAG_BITS        missing tag
//  miss_index     in   INDEX_BITS      missing set
//  line_empty     in   1 x [N_WAYS]    empty flags of set miss_index, valid with miss_valid
//  mem_req_valid  out  1               line read request
//  mem_req_ready  in   1               memory accepts request
//  mem_req_addr   out  TAG+INDEX+WOFF+2  {tag,index,0}; WOFF=$clog2(WORDS_PER_LINE)
//  mem_rsp_valid  in   1               data beat (no backpressure)
//  mem_rsp_data   in   DATA_BITS       beat data, word order 0..WORDS_PER_LINE-1
//  data_we        out  1               data array write strobe
//  data_way       out  N_POW           / data_index INDEX_BITS / data_word WOFF / data_wdata DATA_BITS
//  tag_we         out  1               tag array write strobe
//  tag_way        out  N_POW           / tag_index INDEX_BITS / tag_wdata TAG_BITS
//  tag_empty      out  1               empty value written with tag_we
//  fill_done      out  1               1-cycle pulse when the line commits
//  fill_way       out  N_POW           way filled; valid with fill_done
//  fill_count     out  32              fills completed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. All strobes, mem_req_valid and fill_done are 0. All way/index/addr outputs are 0.
//   Every rr_ptr[set] is 0 and fill_count is 0.
//  FSM: IDLE -> INVAL -> REQ -> FILL -> COMMIT -> IDLE.
//  IDLE: miss_ready=1. On miss_valid, latch tag, index and victim.
//   Victim = lowest-index way with line_empty=1; if none, victim = rr_ptr[index].
//  INVAL (1 cycle): tag_we=1, tag_empty=1, tag_wdata=latched tag. Blocks stale hits during the fill.
//  REQ: mem_req_valid=1 and mem_req_addr stay stable until mem_req_ready, then go to FILL.
//  FILL: each mem_rsp_valid gives data_we=1 in the same cycle, with data_word=beat counter.
//   The counter wraps at WORDS_PER_LINE. The last beat moves to COMMIT. Idle cycles between beats are allowed.
//  COMMIT (1 cycle): tag_we=1, tag_empty=0, fill_done=1, fill_way=victim.
//   If the victim came from rr, rr_ptr[index] = (victim+1) mod N_WAYS; if it came from an empty way, rr is unchanged.
//  mem_rsp_valid outside FILL is ignored; the bench flags it as a protocol error.
//  A back-to-back miss is accepted in the IDLE cycle after COMMIT. Minimum fill = 3 + WORDS_PER_LINE cycles.
//  Reset mid-fill: return to IDLE immediately. The victim stays empty (from INVAL). No fill_done.
//  Non-power-of-two N_WAYS: rr wraps at N_WAYS-1 -> 0, never selects a way >= N_WAYS.
// CONFIGURATION
//  CACHE_FILL_STATS_EN defined: fill_count increments at each COMMIT and wraps at 2**32.
//  Not defined: fill_count is tied to 0 and no counter flops exist.
// STRUCTURE
//  cache_pkg: fill_state_t enum {IDLE,INVAL,REQ,FILL,COMMIT}; WOFF and ADDR_BITS localparam helpers.
//  Sub-module cache_victim_sel: holds the rr_ptr array and empty-first selection.
//   Interface: index, line_empty, update, upd_way -> victim, from_empty.
// TESTING
//  1 Miss tag=0x12345 idx=3 with line_empty={1,1} -> INVAL way0; req addr 0x12345030;
//    4 beats A0..A3 write words 0..3; COMMIT tag_empty=0; fill_done, fill_way=0.
//  2 Set 3 full, rr=0, two misses -> victims way0 then way1. A third miss -> way0 (rr wrap).
//  3 Hold mem_req_ready=0 for 5 cycles -> addr stable, no data_we. Gaps between beats -> word order kept.
//  4 Assert rst_n=0 after 2 beats -> IDLE next edge, outputs at reset values, no fill_done.
//    The next miss fills cleanly.
//  5 line_empty={0,1}, rr=0 -> victim way1, rr stays 0. With CACHE_FILL_STATS_EN: fill_count=1 after
//    one fill; without it: fill_count=0.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and width helpers for the cache line-fill path.
//               fill_state_t encodes the fill sequencer states. woff_bits()
//               and addr_bits() derive the word-offset and memory-address
//               widths from the cache geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Fill sequencer state, with an explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INVAL  = 3'd1,
        REQ    = 3'd2,
        FILL   = 3'd3,
        COMMIT = 3'd4
    } fill_state_t;

    // Memory addresses are byte addresses of 32-bit words.
    localparam int C_BYTE_OFF_BITS = 2;

    // Width of the word-within-line offset.
    function automatic int woff_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Width of the memory request address: {tag, index, word, byte}.
    function automatic int addr_bits(input int tag_bits, input int index_bits,
                                     input int words_per_line);
        return tag_bits + index_bits + woff_bits(words_per_line) + C_BYTE_OFF_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : cache_victim_sel
// Description : Victim way selection for a line fill. The lowest-numbered
//               empty way wins. If the set has no empty way, the per-set
//               round-robin pointer chooses the victim. The pointer advances
//               only when it supplied the victim.
// Ports       : clk, rst_n        clock, async active-low reset
//               index             set being looked up / updated
//               line_empty        per-way empty flags of that set
//               update            advance rr_ptr[index] past upd_way
//               upd_way           way that was just filled from rr
//               victim            selected way
//               from_empty        victim came from an empty way
// Revision    : 1.0 - initial release
// ============================================================================
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int N_WAYS     = 2,
    parameter int N_POW      = 4,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [N_WAYS-1:0]     line_empty,
    input  logic                  update,
    input  logic [N_POW-1:0]      upd_way,
    output logic [N_POW-1:0]      victim,
    output logic                  from_empty
);

    localparam int               N_SETS     = 2 ** INDEX_BITS;
    localparam logic [N_POW-1:0] C_LAST_WAY = N_POW'(N_WAYS - 1);

    logic [N_POW-1:0] rr_q [N_SETS];
    logic [N_POW-1:0] rr_d [N_SETS];
    logic [N_POW-1:0] w_rr_next;

    // The scan runs from the top way down, so the lowest empty way is the
    // last one assigned and therefore wins.
    always_comb begin
        victim     = rr_q[index];
        from_empty = 1'b0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (line_empty[w]) begin
                victim     = N_POW'(w);
                from_empty = 1'b1;
            end
        end
    end

    // The pointer wraps explicitly at the last way, so a non-power-of-two
    // way count never yields a way number that does not exist.
    assign w_rr_next = (upd_way >= C_LAST_WAY) ? '0 : upd_way + N_POW'(1);

    always_comb begin
        for (int s = 0; s < N_SETS; s++) begin
            rr_d[s] = rr_q[s];
        end
        if (update) begin
            rr_d[index] = w_rr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < N_SETS; s++) begin
                rr_q[s] <= rr_d[s];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_line_fill.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_fill
// Description : Cache miss line-fill sequencer. It accepts a miss, picks and
//               invalidates a victim way, and requests the line from memory.
//               It writes each returned beat into the data array, then
//               commits the tag as valid.
//               Sequence: IDLE -> INVAL -> REQ -> FILL -> COMMIT -> IDLE.
// Ports       : miss_*      miss request handshake (miss_ready high in IDLE)
//               line_empty  empty flags of set miss_index, valid with miss_valid
//               mem_req_*   line read request, address {tag,index,0}
//               mem_rsp_*   returned beats, word order 0..WORDS_PER_LINE-1
//               data_*      data array write port
//               tag_*       tag array write port (tag_empty = invalid marker)
//               fill_done   one-cycle pulse on commit, with fill_way
//               fill_count  completed fills
// Config      : CACHE_FILL_STATS_EN - when defined, fill_count counts commits
//               (wrapping at 2**32); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_fill
    import cache_pkg::*;
#(
    parameter int  N_WAYS         = 2,
    parameter int  N_POW          = 4,
    parameter int  TAG_BITS       = 20,
    parameter int  INDEX_BITS     = 8,
    parameter int  WORDS_PER_LINE = 4,
    parameter int  DATA_BITS      = 32,
    localparam int WOFF           = woff_bits(WORDS_PER_LINE),
    localparam int ADDR_BITS      = addr_bits(TAG_BITS, INDEX_BITS, WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [TAG_BITS-1:0]   miss_tag,
    input  logic [INDEX_BITS-1:0] miss_index,
    input  logic [N_WAYS-1:0]     line_empty,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_BITS-1:0]  mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_BITS-1:0]  mem_rsp_data,
    output logic                  data_we,
    output logic [N_POW-1:0]      data_way,
    output logic [INDEX_BITS-1:0] data_index,
    output logic [WOFF-1:0]       data_word,
    output logic [DATA_BITS-1:0]  data_wdata,
    output logic                  tag_we,
    output logic [N_POW-1:0]      tag_way,
    output logic [INDEX_BITS-1:0] tag_index,
    output logic [TAG_BITS-1:0]   tag_wdata,
    output logic                  tag_empty,
    output logic                  fill_done,
    output logic [N_POW-1:0]      fill_way,
    output logic [31:0]           fill_count
);

    localparam logic [WOFF-1:0] C_LAST_BEAT = WOFF'(WORDS_PER_LINE - 1);

    fill_state_t           state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [N_POW-1:0]      victim_q, victim_d;
    logic                  from_empty_q, from_empty_d;
    logic [WOFF-1:0]       beat_q, beat_d;

    logic [INDEX_BITS-1:0] w_sel_index;
    logic [N_POW-1:0]      w_sel_victim;
    logic                  w_sel_from_empty;
    logic                  w_rr_update;
    logic                  w_beat_we;

    // ------------------------------------------------------------------
    // Victim selection. In IDLE the selector looks at the incoming miss.
    // Afterwards it points at the latched set, so the commit-time pointer
    // update lands on the set that was filled.
    // ------------------------------------------------------------------
    assign w_sel_index = (state_q == IDLE) ? miss_index : index_q;
    assign w_rr_update = (state_q == COMMIT) && !from_empty_q;

    cache_victim_sel #(
        .N_WAYS     (N_WAYS),
        .N_POW      (N_POW),
        .INDEX_BITS (INDEX_BITS)
    ) u_victim_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (w_sel_index),
        .line_empty (line_empty),
        .update     (w_rr_update),
        .upd_way    (victim_q),
        .victim     (w_sel_victim),
        .from_empty (w_sel_from_empty)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        victim_d     = victim_q;
        from_empty_d = from_empty_q;
        beat_d       = beat_q;

        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    tag_d        = miss_tag;
                    index_d      = miss_index;
                    victim_d     = w_sel_victim;
                    from_empty_d = w_sel_from_empty;
                    state_d      = INVAL;
                end
            end
            INVAL: begin
                state_d = REQ;
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rsp_valid) begin
                    // The line length is a power of two, so the counter
                    // wraps to zero by itself after the last beat.
                    beat_d = beat_q + WOFF'(1);
                    if (beat_q == C_LAST_BEAT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            victim_q     <= '0;
            from_empty_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            victim_q     <= victim_d;
            from_empty_q <= from_empty_d;
            beat_q       <= beat_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the current state. Beats are written in the
    // cycle they arrive; beats outside FILL are dropped.
    // ------------------------------------------------------------------
    assign w_beat_we = (state_q == FILL) && mem_rsp_valid;

    always_comb begin
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        data_we       = 1'b0;
        data_wdata    = '0;
        tag_we        = 1'b0;
        tag_empty     = 1'b0;
        fill_done     = 1'b0;

        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
            end
            INVAL: begin
                // Mark the victim invalid before refilling it, so lookups
                // cannot hit on stale data while the line is half written.
                tag_we    = 1'b1;
                tag_empty = 1'b1;
            end
            REQ: begin
                mem_req_valid = 1'b1;
            end
            FILL: begin
                data_we    = w_beat_we;
                data_wdata = w_beat_we ? mem_rsp_data : '0;
            end
            COMMIT: begin
                tag_we    = 1'b1;
                fill_done = 1'b1;
            end
            default: begin
                miss_ready = 1'b0;
            end
        endcase
    end

    assign mem_req_addr = {tag_q, index_q, {(WOFF + C_BYTE_OFF_BITS){1'b0}}};
    assign data_way     = victim_q;
    assign data_index   = index_q;
    assign data_word    = beat_q;
    assign tag_way      = victim_q;
    assign tag_index    = index_q;
    assign tag_wdata    = tag_q;
    assign fill_way     = victim_q;

    // ------------------------------------------------------------------
    // Fill statistics
    // ------------------------------------------------------------------
`ifdef CACHE_FILL_STATS_EN
    logic [31:0] fill_count_q, fill_count_d;

    always_comb begin
        fill_count_d = fill_count_q;
        if (state_q == COMMIT) begin
            fill_count_d = fill_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count_q <= '0;
        end else begin
            fill_count_q <= fill_count_d;
        end
    end

    assign fill_count = fill_count_q;
`else
    assign fill_count = 32'd0;
`endif

endmodule
`default_nettype wire
